// File: rtl/synth_div_pkg.sv
// Shared definitions for the tone divider bank: default widths, the channel
// index width helper and the per-channel operating mode.
package synth_div_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_DIV      = 50;
  localparam int MAX_CHANNELS = 16;

  // A single-channel bank still gets a 1-bit select so the port never collapses.
  function automatic int chIdxW(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_HOLD,
    CH_RUN
  } ch_mode_e;

endpackage

// File: rtl/tone_divider_bank_if.sv
// Divisor-write bus, run enables and divided outputs of the tone divider bank.
interface tone_divider_bank_if
  import synth_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = DEF_CNT_W
);

  localparam int CH_W = chIdxW(CHANNELS);

  logic                load;
  logic [CH_W-1:0]     load_ch;
  logic [CNT_W-1:0]    load_div;
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] oclk;
  logic [CHANNELS-1:0] tick;

  modport master (
    output load, load_ch, load_div, en,
    input  oclk, tick
  );

  modport slave (
    input  load, load_ch, load_div, en,
    output oclk, tick
  );

endinterface

// File: rtl/div_channel.sv
// One divider channel: half-period counter with a double-buffered divisor.
// Define DIVIDER_PHASE_RESET_EN to make every write restart the phase at once.
module div_channel
  import synth_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wrDiv_i,
  output logic             oclk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pendValid_q, pendValid_d;
  logic             oclk_q, oclk_d;
  logic             tick_q, tick_d;
  logic             terminal;
  ch_mode_e         mode;

  always_comb begin
    cnt_d       = cnt_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    oclk_d      = oclk_q;
    tick_d      = 1'b0;

    if (active_q == '0) begin
      mode = CH_IDLE;
    end else if (!en_i) begin
      mode = CH_HOLD;
    end else begin
      mode = CH_RUN;
    end
    terminal = (mode == CH_RUN) && (cnt_q == active_q - CNT_W'(1));

`ifdef DIVIDER_PHASE_RESET_EN
    if (wr_i) begin
      active_d    = wrDiv_i;
      cnt_d       = '0;
      oclk_d      = 1'b0;
      pendValid_d = 1'b0;
    end else
`endif
    begin
      // Pending divisors are swapped in only at a half-period boundary, or
      // straight away when nothing is counting.
      case (mode)
        CH_IDLE: begin
          cnt_d  = '0;
          oclk_d = 1'b0;
          if (pendValid_q) begin
            active_d    = pend_q;
            pendValid_d = 1'b0;
          end
        end
        CH_HOLD: begin
          if (pendValid_q) begin
            active_d    = pend_q;
            cnt_d       = '0;
            pendValid_d = 1'b0;
          end
        end
        default: begin
          if (terminal) begin
            cnt_d  = '0;
            oclk_d = ~oclk_q;
            tick_d = 1'b1;
            if (pendValid_q) begin
              active_d    = pend_q;
              pendValid_d = 1'b0;
              // Switching to a zero divisor parks the output low immediately.
              if (pend_q == '0) begin
                oclk_d = 1'b0;
                tick_d = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase

      if (wr_i) begin
        pend_d      = wrDiv_i;
        pendValid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      active_q    <= CNT_W'(DEFAULT_DIV);
      pend_q      <= '0;
      pendValid_q <= 1'b0;
      oclk_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
      oclk_q      <= oclk_d;
      tick_q      <= tick_d;
    end
  end

  assign oclk_o = oclk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/tone_divider_bank.sv
// Bank of independent square-wave dividers; decodes divisor writes to channels.
// Optional hard phase restart on write: define DIVIDER_PHASE_RESET_EN.
module tone_divider_bank
  import synth_div_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input logic clk,
  input logic rst,
  tone_divider_bank_if.slave bus
);

  localparam int CH_W = chIdxW(CHANNELS);

  logic [CHANNELS-1:0] wrSel;

  // Selects that fall outside the bank match no channel and are dropped.
  always_comb begin
    wrSel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wrSel[i] = bus.load && (bus.load_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en_i   (bus.en[i]),
      .wr_i   (wrSel[i]),
      .wrDiv_i(bus.load_div),
      .oclk_o (bus.oclk[i]),
      .tick_o (bus.tick[i])
    );
  end

endmodule

// File: tb/tb_tone_divider_bank.sv
// Scoreboard bench for tone_divider_bank: expected tick events are queued per
// channel and a monitor pops them as the DUT pulses tick.
module tb_tone_divider_bank;

  localparam int CH = 4;

  typedef struct packed {
    int   cyc;
    logic val;
  } evt_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  evt_t expQ[CH][$];

  tone_divider_bank_if #(.CHANNELS(CH), .CNT_W(16)) bus ();

  tone_divider_bank #(
    .CHANNELS   (CH),
    .CNT_W      (16),
    .DEFAULT_DIV(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle k is the state after the k-th rising edge following reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic waitCycle(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int k, input logic [1:0] ch, input logic [15:0] div);
    waitCycle(k - 1);
    bus.load     = 1'b1;
    bus.load_ch  = ch;
    bus.load_div = div;
    waitCycle(k);
    bus.load     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int ch, input logic expO, input logic expT);
    checks++;
    if (bus.oclk[ch] !== expO || bus.tick[ch] !== expT) begin
      failures++;
      $display("[TB] FAIL %s ch%0d cycle=%0d got oclk=%b tick=%b required oclk=%b tick=%b",
               name, ch, cyc, bus.oclk[ch], bus.tick[ch], expO, expT);
    end
  endtask

  task automatic expectRun(input int ch, input int first, input int step, input int last,
                           input logic firstVal);
    logic v;
    v = firstVal;
    for (int c = first; c <= last; c += step) begin
      expQ[ch].push_back('{cyc: c, val: v});
      v = ~v;
    end
  endtask

  task automatic checkQueuesEmpty(input string name);
    for (int ch = 0; ch < CH; ch++) begin
      checks++;
      if (expQ[ch].size() != 0) begin
        failures++;
        $display("[TB] FAIL %s ch%0d missing ticks got %0d outstanding required 0 (next at cycle %0d)",
                 name, ch, expQ[ch].size(), expQ[ch][0].cyc);
      end
    end
  endtask

  task automatic doReset(input logic [CH-1:0] enVal);
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.load_ch  = '0;
    bus.load_div = '0;
    bus.en       = enVal;
    for (int ch = 0; ch < CH; ch++) expQ[ch].delete();
    repeat (3) @(posedge clk);
    #1;
    for (int ch = 0; ch < CH; ch++) checkOutput("reset_state", ch, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin : monitor
    evt_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int ch = 0; ch < CH; ch++) begin
          if (bus.tick[ch]) begin
            checks++;
            if (expQ[ch].size() == 0) begin
              failures++;
              $display("[TB] FAIL tick_unexpected ch%0d cycle=%0d got tick=1 required no tick", ch, cyc);
            end else begin
              e = expQ[ch].pop_front();
              if (e.cyc != cyc || e.val !== bus.oclk[ch]) begin
                failures++;
                $display("[TB] FAIL tick_event ch%0d got cycle=%0d oclk=%b required cycle=%0d oclk=%b",
                         ch, cyc, bus.oclk[ch], e.cyc, e.val);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    checks   = 0;
    failures = 0;

    // Free-running default divisor on all channels.
    doReset(4'b1111);
    for (int ch = 0; ch < CH; ch++) expectRun(ch, 50, 50, 200, 1'b1);
    waitCycle(210);
    for (int ch = 0; ch < CH; ch++) checkOutput("a_low_phase", ch, 1'b0, 1'b0);
    checkQueuesEmpty("a_default");

`ifdef DIVIDER_PHASE_RESET_EN
    // Hard phase restart: ch0 drops on the write edge and rises 4 cycles on.
    doReset(4'b1111);
    expQ[0].push_back('{cyc: 50, val: 1'b1});
    expectRun(0, 74, 4, 100, 1'b1);
    for (int ch = 1; ch < CH; ch++) expectRun(ch, 50, 50, 100, 1'b1);
    applyStimulus(70, 2'd0, 16'd4);
    checkOutput("p_restart_low", 0, 1'b0, 1'b0);
    waitCycle(101);
    checkQueuesEmpty("p_phase_restart");
`else
    // Load ch1 twice before its terminal; the later value takes over at cycle 50.
    doReset(4'b1111);
    for (int ch = 0; ch < CH; ch++) if (ch != 1) expectRun(ch, 50, 50, 150, 1'b1);
    expQ[1].push_back('{cyc: 50, val: 1'b1});
    expectRun(1, 53, 3, 160, 1'b0);
    applyStimulus(8, 2'd1, 16'd9);
    applyStimulus(10, 2'd1, 16'd3);
    waitCycle(160);
    checkQueuesEmpty("b_load_ch1");

    // ch2 parked by a zero divisor, then restarted with 7.
    doReset(4'b1111);
    for (int ch = 0; ch < CH; ch++) if (ch != 2) expectRun(ch, 50, 50, 100, 1'b1);
    expectRun(2, 68, 7, 120, 1'b1);
    applyStimulus(10, 2'd2, 16'd0);
    waitCycle(55);
    checkOutput("c_idle", 2, 1'b0, 1'b0);
    applyStimulus(60, 2'd2, 16'd7);
    waitCycle(120);
    checkQueuesEmpty("c_idle_restart");
`endif

    // ch3 disabled for 20 cycles mid-period.
    doReset(4'b1111);
    for (int ch = 0; ch < 3; ch++) expectRun(ch, 50, 50, 100, 1'b1);
    expectRun(3, 70, 50, 120, 1'b1);
    waitCycle(29);
    bus.en[3] = 1'b0;
    waitCycle(40);
    checkOutput("d_frozen", 3, 1'b0, 1'b0);
    waitCycle(49);
    bus.en[3] = 1'b1;
    waitCycle(130);
    checkQueuesEmpty("d_enable_gap");

`ifndef DIVIDER_PHASE_RESET_EN
    // Reset mid-period with a pending divisor on ch0.
    doReset(4'b1111);
    expectRun(0, 50, 10, 60, 1'b1);
    for (int ch = 1; ch < CH; ch++) expQ[ch].push_back('{cyc: 50, val: 1'b1});
    applyStimulus(5, 2'd0, 16'd10);
    applyStimulus(62, 2'd0, 16'd20);
    waitCycle(65);
    checkQueuesEmpty("e_pre_reset");
    rst = 1'b1;
    #1;
    for (int ch = 0; ch < CH; ch++) checkOutput("e_async_reset", ch, 1'b0, 1'b0);
    doReset(4'b1111);
    for (int ch = 0; ch < CH; ch++) expectRun(ch, 50, 50, 100, 1'b1);
    waitCycle(110);
    checkQueuesEmpty("e_post_reset");

    // Divisor 1 loaded while disabled, then run: toggles and ticks every cycle.
    doReset(4'b0111);
    for (int ch = 0; ch < 3; ch++) expectRun(ch, 50, 50, 100, 1'b1);
    expectRun(3, 10, 1, 20, 1'b1);
    applyStimulus(5, 2'd3, 16'd1);
    waitCycle(9);
    bus.en[3] = 1'b1;
    waitCycle(20);
    bus.en[3] = 1'b0;
    waitCycle(25);
    checkOutput("f_div1_frozen", 3, 1'b1, 1'b0);
    waitCycle(110);
    checkQueuesEmpty("f_div1");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
